// File: rtl/rotor0_fwd_stage.sv
// Forward (keyboard-to-reflector) stage for Enigma rotor 0, which uses the rotor I wiring.
// Owns the rotor position, encodes one letter per accepted transfer and emits a registered carry.
module rotor0_fwd_stage #(
    parameter int NOTCH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] data_in,
    input  logic       step_in,
    input  logic       load_en,
    input  logic [4:0] load_pos,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] data_out,
    output logic [4:0] index,
    output logic       carry_out,
    output logic       err,
    output logic [4:0] position
);

    // Rotor I contact map, EKMFLGDQVZNTOWYHXUSPAIBRCJ
    function automatic logic [4:0] rotor_wire(input logic [4:0] idx);
        logic [4:0] w;
        case (idx)
            5'd0:    w = 5'd4;
            5'd1:    w = 5'd10;
            5'd2:    w = 5'd12;
            5'd3:    w = 5'd5;
            5'd4:    w = 5'd11;
            5'd5:    w = 5'd6;
            5'd6:    w = 5'd3;
            5'd7:    w = 5'd16;
            5'd8:    w = 5'd21;
            5'd9:    w = 5'd25;
            5'd10:   w = 5'd13;
            5'd11:   w = 5'd19;
            5'd12:   w = 5'd14;
            5'd13:   w = 5'd22;
            5'd14:   w = 5'd24;
            5'd15:   w = 5'd7;
            5'd16:   w = 5'd23;
            5'd17:   w = 5'd20;
            5'd18:   w = 5'd18;
            5'd19:   w = 5'd15;
            5'd20:   w = 5'd0;
            5'd21:   w = 5'd8;
            5'd22:   w = 5'd1;
            5'd23:   w = 5'd17;
            5'd24:   w = 5'd2;
            5'd25:   w = 5'd9;
            default: w = 5'd31;
        endcase
        return w;
    endfunction

    // Operands already lie in 0..51, so a single subtract brings the result into 0..25
    function automatic logic [4:0] fold26(input logic [5:0] v);
        logic [5:0] r;
        if (v >= 6'd26) begin
            r = v - 6'd26;
        end else begin
            r = v;
        end
        return r[4:0];
    endfunction

    localparam logic [4:0] NOTCH_POS = 5'(NOTCH);

    logic [4:0] position_r;
    logic       out_valid_r;
    logic [4:0] data_out_r;
    logic [4:0] index_r;
    logic       carry_r;
    logic       err_r;

    logic       accept_s;
    logic [4:0] load_norm_s;
    logic [4:0] pos_eff_s;
    logic       carry_s;
    logic       err_s;
    logic [4:0] index_s;
    logic [4:0] data_s;

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Effective position, carry and encoded letter for the letter currently offered
    always_comb begin
        load_norm_s = fold26({1'b0, load_pos});
        pos_eff_s   = position_r;
        carry_s     = 1'b0;
        if (load_en) begin
            pos_eff_s = load_norm_s;
        end else if (step_in) begin
            pos_eff_s = (position_r == 5'd25) ? 5'd0 : position_r + 5'd1;
            carry_s   = (position_r == NOTCH_POS);
        end else begin
            pos_eff_s = position_r;
        end

        err_s = (data_in >= 5'd26);
        if (err_s) begin
            index_s = 5'd31;
            data_s  = 5'd31;
        end else begin
            index_s = fold26({1'b0, data_in} + {1'b0, pos_eff_s});
            // Adding 26 first keeps the subtraction non-negative
            data_s  = fold26({1'b0, rotor_wire(index_s)} + 6'd26 - {1'b0, pos_eff_s});
        end
    end

    // Position register and output holding register with valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position_r  <= 5'd0;
            out_valid_r <= 1'b0;
            data_out_r  <= 5'd0;
            index_r     <= 5'd0;
            carry_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                position_r <= pos_eff_s;
            end else if (load_en) begin
                position_r <= load_norm_s;
            end

            if (accept_s) begin
                out_valid_r <= 1'b1;
                data_out_r  <= data_s;
                index_r     <= index_s;
                carry_r     <= carry_s;
                err_r       <= err_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign position  = position_r;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign index     = index_r;
    assign carry_out = carry_r;
    assign err       = err_r;

endmodule

// File: doc/rotor0_fwd_stage.md
# rotor0_fwd_stage

Forward-path (keyboard-to-reflector) stage for rotor 0 (Enigma rotor I wiring), the counterpart of the existing reverse rotor-0 difference path. It owns the rotor position register and steps it on request. It encodes one 5-bit letter (0 = A … 25 = Z) per accepted transfer through the position-offset wiring, and emits a registered carry toward the next rotor when the notch is passed. It sits between the plugboard output and rotor 1's forward stage, and uses valid/ready handshakes on both sides.

## Interface
- `NOTCH`, default 16: position from which a step generates carry (Q for rotor I).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input letter valid.
- `in_ready` out 1: stage can accept input.
- `data_in` in 5: letter to encode.
- `step_in` in 1: advance position before encoding this letter; sampled only on accept.
- `load_en` in 1: load rotor position; sampled every cycle.
- `load_pos` in 5: position to load (0–25).
- `out_valid` out 1: output letter valid.
- `out_ready` in 1: downstream accepts the output.
- `data_out` out 5: encoded letter.
- `index` out 5: wiring contact used, (data_in + position) mod 26.
- `carry_out` out 1: step of the next rotor, qualified by `out_valid`.
- `err` out 1: the input letter was ≥ 26, qualified by `out_valid`.
- `position` out 5: current rotor position.

## Operation
- Wiring W[0..25] = 4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9 (EKMFLGDQVZNTOWYHXUSPAIBRCJ).
- Accept occurs when `in_valid && in_ready`.
- Effective position p for an accepted letter:
  - if `load_en`: p = `load_pos`;
  - else if `step_in`: p = (position+1) mod 26, with 25 wrapping to 0;
  - else p = position.
- Encoding: `index` = (data_in + p) mod 26, and `data_out` = (W[index] − p + 26) mod 26. Use 6-bit intermediates with a single conditional subtract of 26; there is no multiply or divide.
- Carry: `carry_out` = 1 only when the step path was taken and position was NOTCH before the step.
  - Load never produces carry.
  - Double-stepping of the middle rotor belongs to the rotor-1 stage, not to this stage.
- Position register:
  - updates to p on accept;
  - on `load_en` without accept, updates to `load_pos`;
  - `load_pos` ≥ 26 is reduced to `load_pos` − 26;
  - otherwise holds.
- Illegal input: when `data_in` ≥ 26, the letter is still accepted and the position still steps. Outputs are `data_out` = 31, `index` = 31, `err` = 1, and `carry_out` is computed normally.
- Output register:
  - loads `data_out`, `index`, `carry_out` and `err` on accept;
  - holds while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous, immediate): `position` = 0, `out_valid` = 0, `data_out` = 0, `index` = 0, `carry_out` = 0, `err` = 0; `in_ready` = 1 after reset.
- Latency is 1 cycle: a letter accepted at edge N is presented with `out_valid` = 1 after edge N.
- `in_ready` = !out_valid || out_ready (combinational). This gives full throughput of one letter per cycle with `out_ready` held high.
- `out_valid`:
  - set on accept;
  - cleared on `out_ready` without a new accept;
  - stays 1 on a simultaneous drain and accept, with the new data loaded.
- Output data is stable while `out_valid && !out_ready`; no upstream letter is accepted in that state.
- `load_en` during a stall updates `position` immediately. A held output keeps its original values.
- `position` reflects the post-accept value in the same cycle `out_valid` rises.
- Reset mid-transfer discards the held output, with no partial handshake.

## Test plan
- Position 0, no step, send 4, 9, then 12 with position loaded to 1 and then 6:
  - 4 → `index` 4, `data_out` 11;
  - at position 1, 9 → `index` 10, `data_out` 12;
  - at position 6, 12 → `index` 18, `data_out` 12.
- Reset, then `data_in` 0 with `step_in` 1 → `position` 1, `index` 1, `data_out` 9 (A→J), `carry_out` 0.
- Load 16, then `data_in` 0 with `step_in` 1 → `position` 17, `index` 17, `data_out` 3, `carry_out` 1. The next stepped letter → `carry_out` 0.
- Load 25, then `data_in` 0 with `step_in` 1 → `position` wraps to 0, `data_out` 4, `carry_out` 0.
- Hold `out_ready` 0 and send two letters:
  - the first is held stable;
  - `in_ready` = 0 and the second is not accepted;
  - raising `out_ready` drains the first and accepts the second in the same cycle.
- Send `data_in` 27 with `step_in` 1 → `data_out` 31, `err` 1, position advances. Assert `rst` while `out_valid` is 1 → outputs and position go to 0 immediately.
